result_serializer: RTL and testbench
====================================

RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter: RESULT_W, 64, width of the calculator result bus; only 64 is supported.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  one-cycle request to capture result and operation.
REQ-005 Port: result  input  64  calculator result; sampled only on an accepted start.
REQ-006 Port: operation  input  2  opcode that produced result: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 Port: abort  input  1  I2C STOP or NACK seen; ends the transfer.
REQ-008 Port: tx_ready  input  1  I2C slave can take a byte this cycle.
REQ-009 Port: tx_data  output  8  current result byte.
REQ-010 Port: tx_valid  output  1  tx_data is valid.
REQ-011 Port: busy  output  1  high when the state is not IDLE.
REQ-012 Port: done  output  1  one-cycle pulse after the last byte transfers.

Function
REQ-013 States SHALL be IDLE, SEND and DONE, held in registers.
REQ-014 In IDLE, start=1 with abort=0 SHALL load result into a 64-bit shift register and a byte count into a 4-bit counter, then move to SEND.
REQ-015 Byte count SHALL be 5 for add/sub, 8 for mul and 4 for div, matching the significant result width.
REQ-016 tx_valid SHALL be 1 in SEND only, starting the cycle after start is accepted (latency 1).
REQ-017 tx_data SHALL equal shift[7:0] while tx_valid=1 and 8'h00 otherwise; bytes go out LSB first.
REQ-018 A byte SHALL transfer on a cycle with tx_valid=1 and tx_ready=1; on transfer, shift moves right 8 and count decrements.
REQ-019 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0, with no time limit.
REQ-020 A transfer while count=1 SHALL move to DONE; DONE SHALL assert done for one cycle and then return to IDLE.
REQ-021 start SHALL be ignored in SEND and DONE; there is no queueing and no error flag.
REQ-022 abort=1 in any state SHALL force IDLE on the next edge, with tx_valid=0 and no done pulse.
REQ-023 abort SHALL take priority over a start or a final transfer in the same cycle; the final byte counts as transferred but done SHALL NOT pulse.
REQ-024 In DONE, start SHALL be ignored; a new start SHALL be accepted in IDLE on the following cycle.
REQ-025 Back-to-back transfers SHALL sustain one byte per cycle while tx_ready stays high.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, shift=0, count=0, tx_valid=0, tx_data=0, busy=0 and done=0.
REQ-027 Reset during SEND SHALL drop the transfer silently; after release, no bytes remain pending.
REQ-028 The first start is accepted on the first rising edge with rst_n=1.

Structure
REQ-029 Opcode constants OPR_ADD/SUB/MUL/DIV, byte counts 5/5/8/4 and the state encoding SHALL live in a shared package calc_pkg, also used by the calculator.
REQ-030 The block SHALL be a single module with no sub-module; the byte-count decode is an inline case.

Verification
REQ-031 Add: operation=00, result=64'h0000_0001_2345_6789, tx_ready=1 -> bytes 89,67,45,23,01 on consecutive cycles, then done one cycle later.
REQ-032 Mul with stalls: operation=10, result=64'h0123_4567_89AB_CDEF, tx_ready toggling 1/0 -> 8 bytes EF..01 in order, each held stable during stalls.
REQ-033 Div: operation=11, result=64'h0000_0000_DEAD_BEEF -> exactly 4 bytes EF,BE,AD,DE, then done; no fifth tx_valid.
REQ-034 Abort after 2 of 5 bytes -> next cycle tx_valid=0 and busy=0, no done; a fresh start then replays from byte 0.
REQ-035 start while busy (result changed) -> ignored; the original bytes complete unchanged.
REQ-036 rst_n low mid-SEND -> all outputs are 0 immediately (asynchronously); after release, start works normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: opcodes, serializer byte counts, serializer state encoding.
package calc_pkg;

  localparam int CALC_RESULT_W = 64;
  localparam int CNT_W         = 4;

  // Opcodes that produced a calculator result
  typedef enum logic [1:0] {
    OPR_ADD = 2'b00,
    OPR_SUB = 2'b01,
    OPR_MUL = 2'b10,
    OPR_DIV = 2'b11
  } opr_e;

  // Serializer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } ser_state_e;

  // Number of significant result bytes per opcode
  localparam logic [CNT_W-1:0] BYTES_ADD = 4'd5;
  localparam logic [CNT_W-1:0] BYTES_SUB = 4'd5;
  localparam logic [CNT_W-1:0] BYTES_MUL = 4'd8;
  localparam logic [CNT_W-1:0] BYTES_DIV = 4'd4;

endpackage

// File: rtl/result_serializer.sv
// Serializes a captured calculator result, LSB byte first, toward an I2C slave byte port.
//
// Handshake: tx_valid/tx_data come straight from registers; a byte moves on every
// rising edge where tx_valid=1 and tx_ready=1. While tx_ready=0, tx_data holds
// indefinitely. abort wins over everything and returns to IDLE without a done pulse.
module result_serializer
  import calc_pkg::*;
#(
  parameter int RESULT_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [RESULT_W-1:0] result,
  input  logic [1:0]          operation,
  input  logic                abort,
  input  logic                tx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  output logic                busy,
  output logic                done
);

  ser_state_e          state_q, state_d;
  logic [RESULT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                xfer;
  logic                accept;

  assign xfer   = (state_q == ST_SEND) && tx_ready;
  assign accept = (state_q == ST_IDLE) && start && !abort;

  // State and datapath registers; reset clears everything so nothing stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; abort overrides both a start and a final transfer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)                       state_d = ST_SEND;
      ST_SEND: if (xfer && (count_q == 4'd1))   state_d = ST_DONE;
      ST_DONE:                                  state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Shift register and byte counter: load on accept, shift right a byte per transfer
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (abort) begin
      shift_d = '0;
      count_d = '0;
    end else if (accept) begin
      shift_d = result;
      unique case (operation)
        OPR_ADD: count_d = BYTES_ADD;
        OPR_SUB: count_d = BYTES_SUB;
        OPR_MUL: count_d = BYTES_MUL;
        OPR_DIV: count_d = BYTES_DIV;
        default: count_d = BYTES_ADD;
      endcase
    end else if (xfer) begin
      shift_d = shift_q >> 8;
      count_d = count_q - 4'd1;
    end
  end

  // Outputs decoded from registered state only, so reset clears them immediately
  always_comb begin
    tx_valid = (state_q == ST_SEND);
    tx_data  = tx_valid ? shift_q[7:0] : 8'h00;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: directed scenarios with literal byte lists plus a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_result_serializer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [63:0] result = '0;
  logic [1:0]  operation = 2'b00;
  logic        abort = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  // Clock / reset block
  always #5 clk = ~clk;

  result_serializer #(.RESULT_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .result    (result),
    .operation (operation),
    .abort     (abort),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .done      (done)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model: bytes still owed to the slave, and a pending done pulse
  logic [7:0] m_q[$];
  bit         m_done = 1'b0;

  // Observed traffic
  logic [7:0] obs_q[$];
  int         obs_t[$];
  int         done_cnt = 0;
  int         done_t = 0;
  int         acc_t = 0;

  // Expected byte list for directed scenarios
  logic [7:0] exp_q[$];

  function automatic int nbytes(input logic [1:0] op);
    case (op)
      2'b10:   return 8;   // mul: full 64-bit product
      2'b11:   return 4;   // div: 32-bit quotient
      default: return 5;   // add/sub: 33-bit result
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_obs(input string name);
    chk({name, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_t.delete();
    done_cnt = 0;
  endtask

  // Model update and traffic capture on each active edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      cyc++;
      if (tx_valid && tx_ready) begin
        obs_q.push_back(tx_data);
        obs_t.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_t = cyc;
      end
      if (abort) begin
        m_q.delete();
        m_done = 1'b0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_q.size() > 0) begin
        if (tx_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_done = 1'b1;
        end
      end else if (start) begin
        acc_t = cyc;
        for (int i = 0; i < nbytes(operation); i++) m_q.push_back(result[8*i +: 8]);
      end
    end
  end

  // Compare process: outputs against the model on every falling edge out of reset
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("tx_valid", 64'(tx_valid), 64'(m_q.size() > 0));
      chk("tx_data",  64'(tx_data),  (m_q.size() > 0) ? 64'(m_q[0]) : 64'h0);
      chk("busy",     64'(busy),     64'((m_q.size() > 0) || m_done));
      chk("done",     64'(done),     64'(m_done));
    end
  end

  // Driver: apply inputs for one cycle, return just after the next rising edge
  task automatic step(input logic s, input logic [63:0] res, input logic [1:0] op,
                      input logic ab, input logic rdy);
    start     = s;
    result    = res;
    operation = op;
    abort     = ab;
    tx_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [63:0] res, input logic [1:0] op, input bit toggle);
    clear_obs();
    step(1'b1, res, op, 1'b0, 1'b1);
    chk("accepted_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 40 && done_cnt == 0; i++)
      step(1'b0, 64'h0, op, 1'b0, toggle ? 1'((i % 2) == 0) : 1'b1);
    chk("done_pulse", 64'(done_cnt), 64'h1);
    step(1'b0, 64'h0, op, 1'b0, 1'b1);
    chk("done_single", 64'(done_cnt), 64'h1);
  endtask

  initial begin
    logic       s, ab, rdy;
    logic [1:0] op;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx_valid", 64'(tx_valid), 64'h0);
    chk("rst_tx_data",  64'(tx_data),  64'h0);
    chk("rst_busy",     64'(busy),     64'h0);
    chk("rst_done",     64'(done),     64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Add, tx_ready held high: five consecutive bytes then done
    run_txn(64'h0000_0001_2345_6789, 2'b00, 1'b0);
    exp_q = '{8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    chk_obs("add");
    chk("first_accept_cycle", 64'(acc_t), 64'h1);
    if (obs_t.size() == 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("add_cycle%0d", i), 64'(obs_t[i]), 64'(acc_t + 1 + i));
      chk("add_done_cycle", 64'(done_t), 64'(acc_t + 6));
    end

    // Mul with tx_ready toggling
    run_txn(64'h0123_4567_89AB_CDEF, 2'b10, 1'b1);
    exp_q = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    chk_obs("mul");

    // Div: exactly four bytes
    run_txn(64'h0000_0000_DEAD_BEEF, 2'b11, 1'b0);
    exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    chk_obs("div");

    // Abort after two of five bytes, then a fresh start replays from byte 0
    clear_obs();
    step(1'b1, 64'h0000_0001_2345_6789, 2'b01, 1'b0, 1'b0);
    step(1'b0, 64'h0, 2'b01, 1'b0, 1'b1);
    step(1'b0, 64'h0, 2'b01, 1'b0, 1'b1);
    step(1'b0, 64'h0, 2'b01, 1'b1, 1'b0);
    chk("abort_tx_valid", 64'(tx_valid), 64'h0);
    chk("abort_busy",     64'(busy),     64'h0);
    step(1'b0, 64'h0, 2'b01, 1'b0, 1'b1);
    chk("abort_no_done", 64'(done_cnt), 64'h0);
    exp_q = '{8'h89, 8'h67};
    chk_obs("abort_partial");
    run_txn(64'h0000_0001_2345_6789, 2'b01, 1'b0);
    exp_q = '{8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    chk_obs("replay");

    // start while busy with a different result is ignored
    clear_obs();
    step(1'b1, 64'h0000_00AA_BBCC_DDEE, 2'b00, 1'b0, 1'b1);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 1'b1);
    step(1'b1, 64'h1111_1111_1111_1111, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 20 && done_cnt == 0; i++) step(1'b0, 64'h0, 2'b10, 1'b0, 1'b1);
    step(1'b0, 64'h0, 2'b00, 1'b0, 1'b0);
    exp_q = '{8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    chk_obs("busy_start");

    // start in DONE ignored, accepted on the following IDLE cycle
    clear_obs();
    step(1'b1, 64'h0000_0000_DEAD_BEEF, 2'b11, 1'b0, 1'b1);
    repeat (4) step(1'b0, 64'h0, 2'b11, 1'b0, 1'b1);
    chk("in_done", 64'(done), 64'h1);
    step(1'b1, 64'h0000_0000_0000_0042, 2'b00, 1'b0, 1'b1);
    chk("done_start_ignored", 64'(busy), 64'h0);
    step(1'b1, 64'h0000_0000_0000_0042, 2'b00, 1'b0, 1'b1);
    chk("idle_start_taken", 64'(busy), 64'h1);
    for (int i = 0; i < 20 && done_cnt < 2; i++) step(1'b0, 64'h0, 2'b00, 1'b0, 1'b1);
    chk("two_dones", 64'(done_cnt), 64'h2);
    step(1'b0, 64'h0, 2'b00, 1'b0, 1'b0);

    // Abort coinciding with the final transfer: byte goes, no done
    clear_obs();
    step(1'b1, 64'h0000_0000_DEAD_BEEF, 2'b11, 1'b0, 1'b1);
    repeat (3) step(1'b0, 64'h0, 2'b11, 1'b0, 1'b1);
    step(1'b0, 64'h0, 2'b11, 1'b1, 1'b1);
    chk("final_abort_busy", 64'(busy), 64'h0);
    step(1'b0, 64'h0, 2'b11, 1'b0, 1'b0);
    chk("final_abort_no_done", 64'(done_cnt), 64'h0);
    exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    chk_obs("final_abort");

    // Reset mid-SEND: outputs drop immediately, nothing pending afterwards
    step(1'b1, 64'h0123_4567_89AB_CDEF, 2'b10, 1'b0, 1'b1);
    step(1'b0, 64'h0, 2'b10, 1'b0, 1'b1);
    step(1'b0, 64'h0, 2'b10, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 64'(tx_valid), 64'h0);
    chk("midrst_tx_data",  64'(tx_data),  64'h0);
    chk("midrst_busy",     64'(busy),     64'h0);
    chk("midrst_done",     64'(done),     64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 64'h0, 2'b00, 1'b0, 1'b1);
    chk("after_rst_idle", 64'(busy), 64'h0);
    run_txn(64'h0123_4567_89AB_CDEF, 2'b10, 1'b0);
    exp_q = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    chk_obs("after_rst");

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      s   = ($urandom_range(0, 2) == 0);
      ab  = ($urandom_range(0, 40) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      op  = 2'($urandom_range(0, 3));
      step(s, {$urandom, $urandom}, op, ab, rdy);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 64'h0, 2'b00, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
